// File: rtl/mandel_pkg.sv
// Shared types and fixed-point helpers for the Mandelbrot scan engine.
// Holds the FSM state enum, the escape threshold and the rescale helper.
package mandel_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_OUT,
    S_DONE
  } state_t;

  // |z|^2 escape bound: 4.0 in a product scaled by 2^(2*fw)
  function automatic logic signed [63:0] esc_thresh(input int fw);
    return 64'sd4 <<< (2 * fw);
  endfunction

  // Rescale a full-width product back to the operand Q format
  function automatic logic signed [63:0] fx_rescale(
    input logic signed [63:0] p,
    input int                 fw
  );
    return p >>> fw;
  endfunction

endpackage

// File: rtl/mandel_scan_engine_if.sv
// Pixel result stream: valid/ready handshake plus pixel coordinates and count.
// master drives results (engine), slave accepts them (frame-buffer writer).
interface mandel_scan_engine_if #(
  parameter int XW     = 10,
  parameter int YW     = 9,
  parameter int ITER_W = 8
);

  logic              pixValid;
  logic              pixReady;
  logic [XW-1:0]     pixX;
  logic [YW-1:0]     pixY;
  logic [ITER_W-1:0] divOut;

  modport master (
    output pixValid, pixX, pixY, divOut,
    input  pixReady
  );

  modport slave (
    input  pixValid, pixX, pixY, divOut,
    output pixReady
  );

endinterface

// File: rtl/mandel_iter_core.sv
// Combinational z <- z^2 + c step with escape test on the current z.
// Ports: zr_i/zi_i current z, cr_i/ci_i c; escape_o, zr_o/zi_o next z (wraps).
module mandel_iter_core
  import mandel_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 12
) (
  input  logic signed [DATA_W-1:0] zr_i,
  input  logic signed [DATA_W-1:0] zi_i,
  input  logic signed [DATA_W-1:0] cr_i,
  input  logic signed [DATA_W-1:0] ci_i,
  output logic                     escape_o,
  output logic signed [DATA_W-1:0] zr_o,
  output logic signed [DATA_W-1:0] zi_o
);

  // two guard bits so sums/doubling of the squares cannot overflow
  localparam int PW = 2 * DATA_W + 2;

  logic signed [PW-1:0] zr2, zi2, zri;
  logic signed [PW-1:0] mag, re, im;

  always_comb begin
    zr2 = PW'(zr_i) * PW'(zr_i);
    zi2 = PW'(zi_i) * PW'(zi_i);
    zri = PW'(zr_i) * PW'(zi_i);
    mag = zr2 + zi2;
    re  = zr2 - zi2;
    im  = zri <<< 1;
    // strict compare: |z|^2 == 4 keeps iterating
    escape_o = 64'(mag) > esc_thresh(FRAC_W);
    zr_o = DATA_W'(fx_rescale(64'(re), FRAC_W)) + cr_i;
    zi_o = DATA_W'(fx_rescale(64'(im), FRAC_W)) + ci_i;
  end

endmodule

// File: rtl/mandel_scan_engine.sv
// Raster-scans a COLS x ROWS grid of c values and streams one iteration
// count per pixel. Ports: Clk_100M, Reset (sync, high), start + startX/Y,
// stepX/Y config, busy, done pulse, pix stream (valid/ready, X, Y, divOut).
module mandel_scan_engine
  import mandel_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 12,
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255,
  parameter int COLS     = 640,
  parameter int ROWS     = 480
) (
  input  logic                     Clk_100M,
  input  logic                     Reset,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] startX,
  input  logic signed [DATA_W-1:0] startY,
  input  logic signed [DATA_W-1:0] stepX,
  input  logic signed [DATA_W-1:0] stepY,
  output logic                     busy,
  output logic                     done,
  mandel_scan_engine_if.master     pix
);

  localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t state_q, state_d;

  logic [XW-1:0] col_q, col_d;
  logic [YW-1:0] row_q, row_d;
  logic [ITER_W-1:0] n_q, n_d;
  logic [ITER_W-1:0] div_q, div_d;

  logic signed [DATA_W-1:0] sx_q, sx_d;
  logic signed [DATA_W-1:0] dx_q, dx_d;
  logic signed [DATA_W-1:0] dy_q, dy_d;
  logic signed [DATA_W-1:0] cr_q, cr_d;
  logic signed [DATA_W-1:0] ci_q, ci_d;
  logic signed [DATA_W-1:0] zr_q, zr_d;
  logic signed [DATA_W-1:0] zi_q, zi_d;

  logic                     esc;
  logic signed [DATA_W-1:0] zr_nx, zi_nx;

  mandel_iter_core #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_core (
    .zr_i     (zr_q),
    .zi_i     (zi_q),
    .cr_i     (cr_q),
    .ci_i     (ci_q),
    .escape_o (esc),
    .zr_o     (zr_nx),
    .zi_o     (zi_nx)
  );

  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      n_q     <= '0;
      div_q   <= '0;
      sx_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      cr_q    <= '0;
      ci_q    <= '0;
      zr_q    <= '0;
      zi_q    <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      n_q     <= n_d;
      div_q   <= div_d;
      sx_q    <= sx_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      cr_q    <= cr_d;
      ci_q    <= ci_d;
      zr_q    <= zr_d;
      zi_q    <= zi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    n_d     = n_q;
    div_d   = div_q;
    sx_d    = sx_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    cr_d    = cr_q;
    ci_d    = ci_q;
    zr_d    = zr_q;
    zi_d    = zi_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sx_d    = startX;
          dx_d    = stepX;
          dy_d    = stepY;
          cr_d    = startX;
          ci_d    = startY;
          col_d   = '0;
          row_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        zr_d    = '0;
        zi_d    = '0;
        n_d     = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        if (esc || n_q == ITER_W'(MAX_ITER)) begin
          div_d   = n_q;
          state_d = S_OUT;
        end else begin
          zr_d = zr_nx;
          zi_d = zi_nx;
          n_d  = n_q + 1'b1;
        end
      end
      S_OUT: begin
        if (pix.pixReady) begin
          if (col_q == XW'(COLS - 1)) begin
            if (row_q == YW'(ROWS - 1)) begin
              state_d = S_DONE;
            end else begin
              col_d   = '0;
              row_d   = row_q + 1'b1;
              cr_d    = sx_q;
              ci_d    = ci_q + dy_q;
              state_d = S_LOAD;
            end
          end else begin
            col_d   = col_q + 1'b1;
            cr_d    = cr_q + dx_q;
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign pix.pixValid = (state_q == S_OUT);
  assign pix.pixX     = col_q;
  assign pix.pixY     = row_q;
  assign pix.divOut   = div_q;
  assign busy = (state_q == S_LOAD) || (state_q == S_ITER) ||
                (state_q == S_OUT);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_mandel_scan_engine.sv
// Scoreboard bench: 4x2 engine for scan/stall/reset/start-ignore,
// 1x1 engine for latency and single-point boundary counts.
module tb_mandel_scan_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst1, start, start1;
  logic signed [15:0] sx, sy, dx, dy;
  logic signed [15:0] sx1, sy1, dx1, dy1;
  logic busy, done, busy1, done1;

  mandel_scan_engine_if #(.XW(2), .YW(1), .ITER_W(8)) pif ();
  mandel_scan_engine_if #(.XW(1), .YW(1), .ITER_W(8)) pif1 ();

  mandel_scan_engine #(.COLS(4), .ROWS(2)) dut (
    .Clk_100M (clk),
    .Reset    (rst),
    .start    (start),
    .startX   (sx),
    .startY   (sy),
    .stepX    (dx),
    .stepY    (dy),
    .busy     (busy),
    .done     (done),
    .pix      (pif)
  );

  mandel_scan_engine #(.COLS(1), .ROWS(1)) dut1 (
    .Clk_100M (clk),
    .Reset    (rst1),
    .start    (start1),
    .startX   (sx1),
    .startY   (sy1),
    .stepX    (dx1),
    .stepY    (dy1),
    .busy     (busy1),
    .done     (done1),
    .pix      (pif1)
  );

  typedef struct packed {
    logic [1:0] x;
    logic       y;
    logic [7:0] d;
  } exp_t;

  exp_t       q[$];
  logic [7:0] q1[$];
  exp_t       e_m;
  logic [7:0] e1_m;

  int checks = 0, passes = 0;
  int done_cnt = 0, done1_cnt = 0;

  // hand-computed counts: c = (1..4, 0) then (1..4, 0.25)
  int exp_main[8] = '{3, 2, 1, 1, 2, 1, 1, 1};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic exp_t mk(input int x, input int y, input int d);
    exp_t e;
    e.x = 2'(x);
    e.y = 1'(y);
    e.d = 8'(d);
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (done1) done1_cnt++;
    if (pif.pixValid && pif.pixReady) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected pixel (%0d,%0d) div %0d",
                 pif.pixX, pif.pixY, pif.divOut);
      end else begin
        e_m = q.pop_front();
        chk("pixX", pif.pixX, e_m.x);
        chk("pixY", pif.pixY, e_m.y);
        chk("divOut", pif.divOut, e_m.d);
      end
    end
    if (pif1.pixValid && pif1.pixReady) begin
      if (q1.size() == 0) begin
        checks++;
        $display("FAIL unexpected 1x1 pixel div %0d", pif1.divOut);
      end else begin
        e1_m = q1.pop_front();
        chk("1x1 pixX", pif1.pixX, 0);
        chk("1x1 pixY", pif1.pixY, 0);
        chk("1x1 divOut", pif1.divOut, e1_m);
      end
    end
  end

  task automatic go(input bit one, input logic [15:0] a,
                    input logic [15:0] b, input logic [15:0] c,
                    input logic [15:0] d);
    if (one) begin
      sx1 = a; sy1 = b; dx1 = c; dy1 = d; start1 = 1'b1;
    end else begin
      sx = a; sy = b; dx = c; dy = d; start = 1'b1;
    end
    tick(1);
    start  = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic push_main();
    for (int i = 0; i < 8; i++) q.push_back(mk(i % 4, i / 4, exp_main[i]));
  endtask

  task automatic wait_frame(input bit one, input int budget,
                            input int base, input string nm);
    int k = 0;
    while (((one ? done1_cnt : done_cnt) == base) && k < budget) begin
      tick(1);
      k++;
    end
    tick(3);
    chk({nm, " done pulses"}, (one ? done1_cnt : done_cnt) - base, 1);
    chk({nm, " busy low"}, one ? busy1 : busy, 0);
  endtask

  task automatic lat1(input int exp_lat, input string nm);
    int k = 0;
    while (!pif1.pixValid && k < 400) begin
      tick(1);
      k++;
    end
    chk(nm, k, exp_lat);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " done"}, done, 0);
    chk({nm, " pixValid"}, pif.pixValid, 0);
    chk({nm, " pixX"}, pif.pixX, 0);
    chk({nm, " pixY"}, pif.pixY, 0);
    chk({nm, " divOut"}, pif.divOut, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    int base;
    int k;
    rst = 1'b1; rst1 = 1'b1; start = 1'b0; start1 = 1'b0;
    sx = '0; sy = '0; dx = '0; dy = '0;
    sx1 = '0; sy1 = '0; dx1 = '0; dy1 = '0;
    pif.pixReady = 1'b1;
    pif1.pixReady = 1'b1;
    tick(3);
    chk_zero("reset");
    rst = 1'b0; rst1 = 1'b0;
    tick(1);

    // c = 2.5: one iteration, then OUT; done right after the accept
    base = done1_cnt;
    q1.push_back(8'd1);
    go(1'b1, 16'h2800, 16'h0000, 16'h0000, 16'h0000);
    chk("busy after start", busy1, 1);
    lat1(3, "latency c=2.5");
    tick(1);
    chk("done after accept", done1, 1);
    chk("pixValid drop", pif1.pixValid, 0);
    chk("busy falls with done", busy1, 0);
    tick(1);
    chk("done one cycle", done1, 0);
    wait_frame(1'b1, 50, base, "c=2.5");

    // c = 0: never escapes, capped at MAX_ITER
    base = done1_cnt;
    q1.push_back(8'd255);
    go(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    lat1(257, "latency c=0");
    wait_frame(1'b1, 50, base, "c=0");

    // c = -2: |z|^2 sits exactly at 4, not an escape
    base = done1_cnt;
    q1.push_back(8'd255);
    go(1'b1, 16'hE000, 16'h0000, 16'h0000, 16'h0000);
    wait_frame(1'b1, 600, base, "c=-2");

    // 4x2 scan with a 10-cycle stall and an ignored start while busy
    base = done_cnt;
    pif.pixReady = 1'b0;
    push_main();
    go(1'b0, 16'h1000, 16'h0000, 16'h1000, 16'h0400);
    k = 0;
    while (!pif.pixValid && k < 50) begin tick(1); k++; end
    chk("first pixel latency", k, 5);
    sx = 16'h2800; dx = 16'h0000; dy = 16'h0000; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      start = 1'b0;
      chk("stall pixValid", pif.pixValid, 1);
      chk("stall pixX", pif.pixX, 0);
      chk("stall pixY", pif.pixY, 0);
      chk("stall divOut", pif.divOut, 3);
    end
    pif.pixReady = 1'b1;
    wait_frame(1'b0, 500, base, "scan");

    // reset during ITER of pixel (2,0): no done, outputs cleared
    q.push_back(mk(0, 0, 3));
    q.push_back(mk(1, 0, 2));
    go(1'b0, 16'h1000, 16'h0000, 16'h1000, 16'h0400);
    k = 0;
    while (!(pif.pixValid && pif.pixX == 2'd1) && k < 50) begin
      tick(1);
      k++;
    end
    chk("reach pixel 1", k < 50, 1);
    tick(2);
    base = done_cnt;
    rst = 1'b1;
    tick(1);
    chk_zero("mid-frame reset");
    tick(2);
    rst = 1'b0;
    tick(5);
    chk("no done after reset", done_cnt - base, 0);
    chk("pending after reset", q.size(), 0);

    // restart begins again at (0,0)
    base = done_cnt;
    push_main();
    go(1'b0, 16'h1000, 16'h0000, 16'h1000, 16'h0400);
    wait_frame(1'b0, 500, base, "restart");

    chk("scoreboard drained", q.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mandel_scan_engine.md
# mandel_scan_engine

Parametrised successor to the single-point `fractal` divergence unit. Sequential Mandelbrot engine that raster-scans a COLS×ROWS grid of complex points from a programmable origin and step, and iterates z ← z² + c per point in signed fixed point. It emits one iteration count per pixel over a valid/ready stream toward the frame-buffer writer. Sits between the register/control front end (startX/startY/stepX/stepY) and the video memory path.

## Interface
- DATA_W, 16: signed fixed-point width of coordinates and z components
- FRAC_W, 12: fractional bits (Q(DATA_W-FRAC_W).FRAC_W)
- ITER_W, 8: width of iteration count
- MAX_ITER, 255: iteration cap, ≤ 2^ITER_W−1
- COLS, 640 / ROWS, 480: grid dimensions
- Clk_100M  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- start  in  1  begin frame; sampled only in IDLE
- startX, startY  in  DATA_W  signed c of pixel (0,0)
- stepX, stepY  in  DATA_W  signed per-column / per-row increment
- busy  out  1  high from LOAD of first pixel until done
- done  out  1  one-cycle pulse after last pixel accepted
- pixValid  out  1  pixel result available
- pixReady  in  1  downstream accepts when pixValid && pixReady
- pixX  out  $clog2(COLS)  column of current result
- pixY  out  $clog2(ROWS)  row of current result
- divOut  out  ITER_W  iteration count

## Operation
- States: IDLE, LOAD, ITER, OUT, DONE.
- IDLE: start=1 latches startX/Y, stepX/Y; col=row=0; cr=startX, ci=startY; → LOAD. start while not IDLE ignored.
- LOAD (1 cycle): zr=zi=0, n=0; → ITER.
- ITER (1 cycle/iteration): compute zr², zi², zr·zi at 2·DATA_W signed. If zr²+zi² > 4<<(2·FRAC_W) (strict), or n==MAX_ITER: divOut=n, → OUT. Else zr=((zr²−zi²)>>>FRAC_W)+cr, zi=((2·zr·zi)>>>FRAC_W)+ci, truncated to DATA_W (wrap, no saturation), n=n+1.
- Result: non-escaping point yields divOut=MAX_ITER. Results are correct for |cr|,|ci| < 2^(DATA_W−FRAC_W−2).
- OUT: pixValid=1; pixX/pixY/divOut held stable until handshake. On accept: if col==COLS−1 and row==ROWS−1 → DONE; elif col==COLS−1: col=0, row++, cr=startX, ci+=stepY → LOAD; else col++, cr+=stepX → LOAD.
- DONE: done=1 for one cycle, → IDLE.
- Coordinate accumulation is by repeated addition, DATA_W wrap.
- Reset at any point: → IDLE, frame aborted, no done.

## Timing
- Reset values: busy=0, done=0, pixValid=0, pixX=0, pixY=0, divOut=0.
- start high at edge 0: LOAD in cycle 1, ITER cycles 2..2+n, pixValid high from cycle 3+n.
- Per-pixel cost: divOut+3 cycles, plus any stall cycles.
- pixValid drops the cycle after accept. No back-to-back pixels, because LOAD is always interposed.
- done asserts the cycle after the final accept. busy falls with done. start is accepted again the next cycle.
- pixReady while pixValid=0 has no effect.

## Structure
- Package mandel_pkg: state enum; function/constant for escape threshold 4<<(2·FRAC_W); fixed-point multiply-and-rescale helper.
- Sub-module mandel_iter_core: combinational squares, cross product, escape compare and next-z computation; parametrised by DATA_W/FRAC_W.
- Top module holds FSM, scan counters, c accumulators, and output registers.

## Test plan
- COLS=ROWS=1, startX=0x2800 (2.5), startY=0 → divOut=1, pixValid at cycle 4 after start, done the cycle after accept.
- c=(0,0), MAX_ITER=255 → divOut=255 after 258 cycles. c=(−2.0,0) (0xE000) → divOut=255 (|z|²==4 is not an escape).
- COLS=4, ROWS=2, startX=0x1000, stepX=0x1000, startY=0, stepY=0x0400 → pixels in raster order (0,0),(1,0)…(3,1). Counts match the golden model. Exactly one done.
- pixReady held low for 10 cycles during OUT → pixX/pixY/divOut/pixValid stable, and no next pixel starts.
- Reset asserted mid-ITER of pixel (2,0) → all outputs zero the next cycle, no done. A new start restarts at (0,0).
- start pulsed while busy → ignored; frame completes with originally latched parameters.
